// File: rtl/axilite_mem_agent_if.sv
// AXI4-Lite bus bundle between a manager and the axilite_mem_agent responder.
interface axilite_mem_agent_if #(
    parameter int AW = 64,
    parameter int DW = 64
);
    logic [AW-1:0]   axi_awaddr;
    logic [2:0]      axi_awprot;
    logic            axi_awvalid;
    logic            axi_awready;
    logic [DW-1:0]   axi_wdata;
    logic [DW/8-1:0] axi_wstrb;
    logic            axi_wvalid;
    logic            axi_wready;
    logic [1:0]      axi_bresp;
    logic            axi_bvalid;
    logic            axi_bready;
    logic [AW-1:0]   axi_araddr;
    logic [2:0]      axi_arprot;
    logic            axi_arvalid;
    logic            axi_arready;
    logic [DW-1:0]   axi_rdata;
    logic [1:0]      axi_rresp;
    logic            axi_rvalid;
    logic            axi_rready;

    modport slave (
        input  axi_awaddr, axi_awprot, axi_awvalid,
        output axi_awready,
        input  axi_wdata, axi_wstrb, axi_wvalid,
        output axi_wready,
        output axi_bresp, axi_bvalid,
        input  axi_bready,
        input  axi_araddr, axi_arprot, axi_arvalid,
        output axi_arready,
        output axi_rdata, axi_rresp, axi_rvalid,
        input  axi_rready
    );

    modport master (
        output axi_awaddr, axi_awprot, axi_awvalid,
        input  axi_awready,
        output axi_wdata, axi_wstrb, axi_wvalid,
        input  axi_wready,
        input  axi_bresp, axi_bvalid,
        output axi_bready,
        output axi_araddr, axi_arprot, axi_arvalid,
        input  axi_arready,
        input  axi_rdata, axi_rresp, axi_rvalid,
        output axi_rready
    );
endinterface

// File: rtl/axilite_mem_agent.sv
// AXI4-Lite responder backed by a word RAM. Independent read and write
// paths, one outstanding transaction per direction, byte-strobed writes,
// SLVERR for addresses beyond the RAM.
module axilite_mem_agent #(
    parameter int AW       = 64,
    parameter int DW       = 64,
    parameter int RAMDEPTH = 4096
) (
    input logic                clk,
    input logic                nreset,
    axilite_mem_agent_if.slave axi
);
    localparam int unsigned NB   = DW / 8;
    localparam int unsigned OFFW = $clog2(NB);
    localparam int unsigned IDXW = $clog2(RAMDEPTH);
    localparam logic [AW-1:0] ADDR_LIMIT = AW'(RAMDEPTH * NB);

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    logic [DW-1:0] mem [RAMDEPTH];

    // write-side buffers and response
    logic            aw_full;
    logic [AW-1:0]   aw_addr;
    logic            w_full;
    logic [DW-1:0]   w_data;
    logic [NB-1:0]   w_strb;
    logic            bvalid_q;
    logic [1:0]      bresp_q;

    // read-side response
    logic            rvalid_q;
    logic [1:0]      rresp_q;
    logic [DW-1:0]   rdata_q;

    logic            aw_hs;
    logic            w_hs;
    logic            b_hs;
    logic            ar_hs;
    logic            r_hs;
    logic            commit;
    logic [IDXW-1:0] aw_idx;
    logic            aw_in_range;
    logic [IDXW-1:0] ar_idx;
    logic            ar_in_range;

    // prot fields carry no meaning for a plain memory
    logic unused_prot;
    assign unused_prot = ^{axi.axi_awprot, axi.axi_arprot};

    assign axi.axi_awready = ~aw_full;
    assign axi.axi_wready  = ~w_full;
    assign axi.axi_bvalid  = bvalid_q;
    assign axi.axi_bresp   = bresp_q;
    assign axi.axi_arready = ~rvalid_q;
    assign axi.axi_rvalid  = rvalid_q;
    assign axi.axi_rresp   = rresp_q;
    assign axi.axi_rdata   = rdata_q;

    // handshakes, commit condition and address decode
    always_comb begin
        aw_hs       = axi.axi_awvalid & ~aw_full;
        w_hs        = axi.axi_wvalid & ~w_full;
        b_hs        = bvalid_q & axi.axi_bready;
        ar_hs       = axi.axi_arvalid & ~rvalid_q;
        r_hs        = rvalid_q & axi.axi_rready;
        commit      = aw_full & w_full & ~bvalid_q;
        aw_idx      = aw_addr[OFFW +: IDXW];
        aw_in_range = aw_addr < ADDR_LIMIT;
        ar_idx      = axi.axi_araddr[OFFW +: IDXW];
        ar_in_range = axi.axi_araddr < ADDR_LIMIT;
    end

    // write-address buffer: loads on handshake, empties on commit
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            aw_full <= 1'b0;
            aw_addr <= '0;
        end else if (commit) begin
            aw_full <= 1'b0;
        end else if (aw_hs) begin
            aw_full <= 1'b1;
            aw_addr <= axi.axi_awaddr;
        end
    end

    // write-data buffer: loads on handshake, empties on commit
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            w_full <= 1'b0;
            w_data <= '0;
            w_strb <= '0;
        end else if (commit) begin
            w_full <= 1'b0;
        end else if (w_hs) begin
            w_full <= 1'b1;
            w_data <= axi.axi_wdata;
            w_strb <= axi.axi_wstrb;
        end
    end

    // write response: raised by commit, held until the manager takes it
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            bvalid_q <= 1'b0;
            bresp_q  <= RESP_OKAY;
        end else if (commit) begin
            bvalid_q <= 1'b1;
            bresp_q  <= aw_in_range ? RESP_OKAY : RESP_SLVERR;
        end else if (b_hs) begin
            bvalid_q <= 1'b0;
        end
    end

    // RAM byte-lane write on an in-range commit; contents survive reset
    always_ff @(posedge clk) begin
        if (commit && aw_in_range) begin
            for (int unsigned i = 0; i < NB; i++) begin
                if (w_strb[i]) begin
                    mem[aw_idx][i*8 +: 8] <= w_data[i*8 +: 8];
                end
            end
        end
    end

    // read response; a read coinciding with a commit sees the old word
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            rvalid_q <= 1'b0;
            rresp_q  <= RESP_OKAY;
            rdata_q  <= '0;
        end else if (ar_hs) begin
            rvalid_q <= 1'b1;
            rresp_q  <= ar_in_range ? RESP_OKAY : RESP_SLVERR;
            rdata_q  <= ar_in_range ? mem[ar_idx] : '0;
        end else if (r_hs) begin
            rvalid_q <= 1'b0;
        end
    end
endmodule

// File: tb/tb_axilite_mem_agent.sv
// Self-checking bench for axilite_mem_agent: directed scenarios with literal
// expectations plus randomized traffic checked every cycle against a
// transaction-level model (queues of accepted requests, sparse memory).
module tb_axilite_mem_agent;
    localparam int AW = 64;
    localparam int DW = 64;
    localparam int RAMDEPTH = 4096;

    logic clk = 1'b0;
    logic nreset = 1'b1;
    always #5 clk = ~clk;

    axilite_mem_agent_if #(.AW(AW), .DW(DW)) bus ();

    axilite_mem_agent #(.AW(AW), .DW(DW), .RAMDEPTH(RAMDEPTH)) dut (
        .clk    (clk),
        .nreset (nreset),
        .axi    (bus)
    );

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [63:0] aw_q [$];
    logic [63:0] wd_q [$];
    logic [7:0]  ws_q [$];
    bit          m_b;
    logic [1:0]  m_bresp;
    bit          m_r;
    logic [1:0]  m_rresp;
    logic [63:0] m_rdata;
    logic [63:0] m_rmask;
    logic [63:0] mm [int];
    logic [7:0]  mk [int];

    function automatic bit in_range(input logic [63:0] a);
        return a < 64'h8000;
    endfunction

    function automatic int widx(input logic [63:0] a);
        return int'(a[14:3]);
    endfunction

    always @(negedge clk) begin : monitor
        bit commit, awhs, whs, bhs, arhs, rhs;
        logic [63:0] ca, cd, tmp, msk;
        logic [7:0] cs, km;
        int idx;
        if (!nreset) begin
            aw_q.delete(); wd_q.delete(); ws_q.delete();
            m_b = 0; m_r = 0;
            check("rst_awready", 64'(bus.axi_awready), 64'd1);
            check("rst_wready",  64'(bus.axi_wready),  64'd1);
            check("rst_arready", 64'(bus.axi_arready), 64'd1);
            check("rst_bvalid",  64'(bus.axi_bvalid),  64'd0);
            check("rst_rvalid",  64'(bus.axi_rvalid),  64'd0);
            check("rst_bresp",   64'(bus.axi_bresp),   64'd0);
            check("rst_rresp",   64'(bus.axi_rresp),   64'd0);
            check("rst_rdata",   bus.axi_rdata,        64'd0);
        end else begin
            check("m_awready", 64'(bus.axi_awready), 64'(aw_q.size() == 0));
            check("m_wready",  64'(bus.axi_wready),  64'(wd_q.size() == 0));
            check("m_bvalid",  64'(bus.axi_bvalid),  64'(m_b));
            check("m_arready", 64'(bus.axi_arready), 64'(!m_r));
            check("m_rvalid",  64'(bus.axi_rvalid),  64'(m_r));
            if (m_b) check("m_bresp", 64'(bus.axi_bresp), 64'(m_bresp));
            if (m_r) begin
                check("m_rresp", 64'(bus.axi_rresp), 64'(m_rresp));
                if (m_rmask != 0) check("m_rdata", bus.axi_rdata & m_rmask, m_rdata & m_rmask);
            end
            // transitions at the coming rising edge
            commit = aw_q.size() > 0 && wd_q.size() > 0 && !m_b;
            awhs   = bus.axi_awvalid && aw_q.size() == 0;
            whs    = bus.axi_wvalid && wd_q.size() == 0;
            bhs    = m_b && bus.axi_bready;
            arhs   = bus.axi_arvalid && !m_r;
            rhs    = m_r && bus.axi_rready;
            if (arhs) begin
                m_r = 1;
                if (in_range(bus.axi_araddr)) begin
                    idx = widx(bus.axi_araddr);
                    m_rresp = 2'b00;
                    m_rdata = mm.exists(idx) ? mm[idx] : 64'd0;
                    km = mk.exists(idx) ? mk[idx] : 8'd0;
                    msk = '0;
                    for (int i = 0; i < 8; i++) if (km[i]) msk[i*8 +: 8] = 8'hFF;
                    m_rmask = msk;
                end else begin
                    m_rresp = 2'b10;
                    m_rdata = '0;
                    m_rmask = '1;
                end
            end else if (rhs) begin
                m_r = 0;
            end
            if (commit) begin
                ca = aw_q.pop_front();
                cd = wd_q.pop_front();
                cs = ws_q.pop_front();
                if (in_range(ca)) begin
                    idx = widx(ca);
                    tmp = mm.exists(idx) ? mm[idx] : 64'd0;
                    km  = mk.exists(idx) ? mk[idx] : 8'd0;
                    for (int i = 0; i < 8; i++) begin
                        if (cs[i]) begin
                            tmp[i*8 +: 8] = cd[i*8 +: 8];
                            km[i] = 1'b1;
                        end
                    end
                    mm[idx] = tmp;
                    mk[idx] = km;
                end
                m_b = 1;
                m_bresp = in_range(ca) ? 2'b00 : 2'b10;
            end else if (bhs) begin
                m_b = 0;
            end
            if (awhs) aw_q.push_back(bus.axi_awaddr);
            if (whs) begin
                wd_q.push_back(bus.axi_wdata);
                ws_q.push_back(bus.axi_wstrb);
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic send_write(input logic [63:0] a, input logic [63:0] d, input logic [7:0] s);
        bit aw_done, w_done, aw_go, w_go;
        aw_done = 0; w_done = 0;
        bus.axi_awaddr = a; bus.axi_awvalid = 1'b1;
        bus.axi_wdata = d; bus.axi_wstrb = s; bus.axi_wvalid = 1'b1;
        for (int n = 0; n < 20 && !(aw_done && w_done); n++) begin
            @(negedge clk);
            aw_go = bus.axi_awvalid && bus.axi_awready;
            w_go  = bus.axi_wvalid && bus.axi_wready;
            @(posedge clk); #1;
            if (aw_go) begin aw_done = 1; bus.axi_awvalid = 1'b0; end
            if (w_go) begin w_done = 1; bus.axi_wvalid = 1'b0; end
        end
        bus.axi_awvalid = 1'b0;
        bus.axi_wvalid = 1'b0;
        check("write_handshake", 64'(aw_done && w_done), 64'd1);
    endtask

    task automatic write_expect(input logic [63:0] a, input logic [63:0] d, input logic [7:0] s,
                                input logic [1:0] resp);
        bus.axi_bready = 1'b1;
        send_write(a, d, s);
        @(negedge clk);
        check("b_not_early", 64'(bus.axi_bvalid), 64'd0);
        @(negedge clk);
        check("b_latency", 64'(bus.axi_bvalid), 64'd1);
        check("bresp", 64'(bus.axi_bresp), 64'(resp));
        @(posedge clk); #1;
    endtask

    task automatic read_expect(input logic [63:0] a, input logic [63:0] d, input logic [1:0] resp);
        bit done, go;
        done = 0;
        bus.axi_araddr = a; bus.axi_arvalid = 1'b1; bus.axi_rready = 1'b1;
        for (int n = 0; n < 20 && !done; n++) begin
            @(negedge clk);
            go = bus.axi_arvalid && bus.axi_arready;
            @(posedge clk); #1;
            if (go) begin done = 1; bus.axi_arvalid = 1'b0; end
        end
        bus.axi_arvalid = 1'b0;
        check("read_handshake", 64'(done), 64'd1);
        @(negedge clk);
        check("r_latency", 64'(bus.axi_rvalid), 64'd1);
        check("rdata", bus.axi_rdata, d);
        check("rresp", 64'(bus.axi_rresp), 64'(resp));
        @(posedge clk); #1;
    endtask

    function automatic logic [63:0] pick_addr();
        logic [63:0] pool [10];
        pool = '{64'h0, 64'h8, 64'h40, 64'h43, 64'h48, 64'h50, 64'h7FFF,
                 64'h8000, 64'h8043, 64'h1_0000_0040};
        return pool[$urandom_range(0, 9)];
    endfunction

    // ---------------- main sequence ----------------
    initial begin
        bit awg, wg, arg;
        bus.axi_awaddr = '0; bus.axi_awprot = '0; bus.axi_awvalid = 1'b0;
        bus.axi_wdata = '0; bus.axi_wstrb = '0; bus.axi_wvalid = 1'b0;
        bus.axi_bready = 1'b0;
        bus.axi_araddr = '0; bus.axi_arprot = '0; bus.axi_arvalid = 1'b0;
        bus.axi_rready = 1'b0;
        #1 nreset = 1'b0;
        repeat (3) @(posedge clk);
        #1 nreset = 1'b1;

        // full write then read, strobed overwrite
        write_expect(64'h40, 64'h1122334455667788, 8'hFF, 2'b00);
        read_expect(64'h40, 64'h1122334455667788, 2'b00);
        write_expect(64'h40, 64'hAAAAAAAAAAAAAAAA, 8'h0F, 2'b00);
        read_expect(64'h40, 64'h11223344AAAAAAAA, 2'b00);

        // out of range aliases onto word 0 by index but must not touch it
        write_expect(64'h0, 64'h0123456789ABCDEF, 8'hFF, 2'b00);
        write_expect(64'h8000, 64'hDEADBEEFDEADBEEF, 8'hFF, 2'b10);
        read_expect(64'h8000, 64'h0, 2'b10);
        read_expect(64'h0, 64'h0123456789ABCDEF, 2'b00);

        // W three cycles ahead of AW, then a second pair under held bvalid
        bus.axi_bready = 1'b0;
        bus.axi_wdata = 64'h5555555555555555; bus.axi_wstrb = 8'hFF; bus.axi_wvalid = 1'b1;
        @(negedge clk);
        check("w_first_ready", 64'(bus.axi_wready), 64'd1);
        @(posedge clk); #1;
        bus.axi_wvalid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        bus.axi_awaddr = 64'h48; bus.axi_awvalid = 1'b1;
        @(posedge clk); #1;
        bus.axi_awvalid = 1'b0;
        @(negedge clk);
        check("order_b_early", 64'(bus.axi_bvalid), 64'd0);
        @(negedge clk);
        check("order_b_valid", 64'(bus.axi_bvalid), 64'd1);
        @(posedge clk); #1;
        bus.axi_wdata = 64'h0F0F0F0F0F0F0F0F; bus.axi_wstrb = 8'hF0; bus.axi_wvalid = 1'b1;
        @(posedge clk); #1;
        bus.axi_wvalid = 1'b0;
        bus.axi_awaddr = 64'h48; bus.axi_awvalid = 1'b1;
        @(negedge clk);
        check("w2_wready_low", 64'(bus.axi_wready), 64'd0);
        @(posedge clk); #1;
        bus.axi_awvalid = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("held_bvalid", 64'(bus.axi_bvalid), 64'd1);
            check("held_bresp", 64'(bus.axi_bresp), 64'd0);
        end
        @(posedge clk); #1;
        bus.axi_bready = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        check("b_drop", 64'(bus.axi_bvalid), 64'd0);
        @(negedge clk);
        check("b_second", 64'(bus.axi_bvalid), 64'd1);
        @(posedge clk); #1;
        read_expect(64'h48, 64'h0F0F0F0F55555555, 2'b00);

        // read backpressure
        bus.axi_rready = 1'b0;
        bus.axi_araddr = 64'h40; bus.axi_arvalid = 1'b1;
        @(posedge clk); #1;
        bus.axi_arvalid = 1'b0;
        repeat (5) begin
            @(negedge clk);
            check("bp_rvalid", 64'(bus.axi_rvalid), 64'd1);
            check("bp_arready", 64'(bus.axi_arready), 64'd0);
            check("bp_rdata", bus.axi_rdata, 64'h11223344AAAAAAAA);
        end
        @(posedge clk); #1;
        bus.axi_rready = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        check("bp_release_rvalid", 64'(bus.axi_rvalid), 64'd0);
        check("bp_release_arready", 64'(bus.axi_arready), 64'd1);

        // reset with a held write response and a blocked read pending
        bus.axi_bready = 1'b0;
        send_write(64'h50, 64'hCAFEF00D12345678, 8'hFF);
        @(negedge clk);
        @(negedge clk);
        check("pre_rst_bvalid", 64'(bus.axi_bvalid), 64'd1);
        @(posedge clk); #1;
        bus.axi_rready = 1'b0;
        bus.axi_araddr = 64'h40; bus.axi_arvalid = 1'b1;
        bus.axi_wdata = 64'h9999999999999999; bus.axi_wstrb = 8'hFF; bus.axi_wvalid = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        nreset = 1'b0;
        #1;
        check("mid_rst_bvalid", 64'(bus.axi_bvalid), 64'd0);
        check("mid_rst_rvalid", 64'(bus.axi_rvalid), 64'd0);
        check("mid_rst_awready", 64'(bus.axi_awready), 64'd1);
        check("mid_rst_wready", 64'(bus.axi_wready), 64'd1);
        check("mid_rst_arready", 64'(bus.axi_arready), 64'd1);
        bus.axi_arvalid = 1'b0; bus.axi_wvalid = 1'b0;
        repeat (3) @(posedge clk);
        #1 nreset = 1'b1;
        read_expect(64'h40, 64'h11223344AAAAAAAA, 2'b00);
        read_expect(64'h50, 64'hCAFEF00D12345678, 2'b00);

        // randomized traffic, valids held until accepted
        awg = 0; wg = 0; arg = 0;
        for (int cyc = 0; cyc < 1500; cyc++) begin
            @(negedge clk);
            awg = bus.axi_awvalid && bus.axi_awready;
            wg  = bus.axi_wvalid && bus.axi_wready;
            arg = bus.axi_arvalid && bus.axi_arready;
            @(posedge clk); #1;
            if (!bus.axi_awvalid || awg) begin
                bus.axi_awvalid = ($urandom_range(0, 2) == 0);
                bus.axi_awaddr = pick_addr();
            end
            if (!bus.axi_wvalid || wg) begin
                bus.axi_wvalid = ($urandom_range(0, 2) == 0);
                bus.axi_wdata = {$urandom(), $urandom()};
                bus.axi_wstrb = 8'($urandom_range(0, 255));
            end
            if (!bus.axi_arvalid || arg) begin
                bus.axi_arvalid = ($urandom_range(0, 1) == 0);
                bus.axi_araddr = pick_addr();
            end
            bus.axi_bready = ($urandom_range(0, 3) != 0);
            bus.axi_rready = ($urandom_range(0, 3) != 0);
        end
        // let any accepted request finish before stopping stimulus
        for (int n = 0; n < 20 && (bus.axi_awvalid || bus.axi_wvalid || bus.axi_arvalid); n++) begin
            @(negedge clk);
            awg = bus.axi_awvalid && bus.axi_awready;
            wg  = bus.axi_wvalid && bus.axi_wready;
            arg = bus.axi_arvalid && bus.axi_arready;
            @(posedge clk); #1;
            bus.axi_bready = 1'b1; bus.axi_rready = 1'b1;
            if (awg) bus.axi_awvalid = 1'b0;
            if (wg) bus.axi_wvalid = 1'b0;
            if (arg) bus.axi_arvalid = 1'b0;
        end
        bus.axi_awvalid = 1'b0; bus.axi_wvalid = 1'b0; bus.axi_arvalid = 1'b0;
        bus.axi_bready = 1'b1; bus.axi_rready = 1'b1;
        repeat (10) @(posedge clk);
        @(negedge clk);
        check("drain_bvalid", 64'(bus.axi_bvalid), 64'd0);
        check("drain_rvalid", 64'(bus.axi_rvalid), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
